pr_stats_rate: RTL and testbench

- Consumes the cumulative `xdma_stat_t` bundle (six 32-bit DMA event counters) produced by the PR statistics stage.
- Every `INTERVAL_CYCLES` clocks it snapshots the counters and computes per-interval deltas.
- Exposes snapshot, delta, epoch and status through a small valid/ready register-read port.
- Sits between the stats stage and the dynamic-region control/register file.

---
 rtl/pr_stats_rate.sv | 201 ++++++++++++++++++++
 tb/tb_pr_stats_rate.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_stats_rate.sv
// pr_stats_rate: samples six cumulative DMA event counters once per interval,
// keeps snapshot and per-interval delta registers plus an epoch count, and
// serves them through a one-deep valid/ready register-read port.
// Optional feature macro: PR_STATS_RATE_PEAK_EN adds per-counter peak-delta
// registers readable at addresses 16..21.
module pr_stats_rate #(
  parameter int unsigned INTERVAL_CYCLES = 250000000,
  parameter int unsigned TMR_BITS        = 32
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [191:0] xdma_stats,
  input  logic         ctrl_clear,
  input  logic         ctrl_freeze,
  input  logic         rd_req_valid,
  output logic         rd_req_ready,
  input  logic [4:0]   rd_req_addr,
  output logic         rd_rsp_valid,
  input  logic         rd_rsp_ready,
  output logic [31:0]  rd_rsp_data,
  output logic         tick
);

  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(INTERVAL_CYCLES - 1);

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RSP  = 1'b1
  } rd_state_t;

  logic [TMR_BITS-1:0] r_timer;
  logic [31:0]         r_prev  [6];
  logic [31:0]         r_snap  [6];
  logic [31:0]         r_delta [6];
  logic [31:0]         r_epoch;
  logic                r_overrun;
  logic                r_tick;
  logic [31:0]         r_rsp_data;
  rd_state_t           r_state;
  rd_state_t           w_state_next;

  logic [31:0]         w_cnt   [6];
  logic [31:0]         w_delta [6];
  logic                w_big;
  logic                w_sample;
  logic                w_commit;
  logic                w_accept;
  logic [2:0]          w_idx;
  logic [31:0]         w_rd_data;

`ifdef PR_STATS_RATE_PEAK_EN
  logic [31:0]         r_peak [6];
`endif

  // c0 is the first struct field, so it occupies the most significant word.
  // Deltas are plain 32-bit subtraction, so counter wrap needs no handling.
  genvar g;
  for (g = 0; g < 6; g++) begin : g_cnt
    assign w_cnt[g]   = xdma_stats[191-32*g -: 32];
    assign w_delta[g] = w_cnt[g] - r_prev[g];
  end

  assign w_sample     = (r_timer == TMR_LAST);
  assign w_commit     = w_sample & ~ctrl_freeze & ~ctrl_clear;
  assign rd_rsp_valid = (r_state == RD_RSP);
  assign rd_req_ready = ~rd_rsp_valid | rd_rsp_ready;
  assign w_accept     = rd_req_valid & rd_req_ready;
  assign w_idx        = rd_req_addr[2:0];
  assign rd_rsp_data  = r_rsp_data;
  assign tick         = r_tick;

  // Any delta above 0x7FFFFFFF has bit 31 set.
  always_comb begin
    w_big = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w_big = w_big | w_delta[i][31];
    end
  end

  // Interval timer: wraps at terminal count, restarted by clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_timer <= '0;
    end else if (ctrl_clear || w_sample) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMR_BITS'(1);
    end
  end

  // Baseline for delta computation: follows each commit or a clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 6; i++) r_prev[i] <= '0;
    end else if (ctrl_clear || w_commit) begin
      for (int i = 0; i < 6; i++) r_prev[i] <= w_cnt[i];
    end
  end

  // Snapshot, delta and epoch commit together on an unfrozen sample cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 6; i++) begin
        r_snap[i]  <= '0;
        r_delta[i] <= '0;
      end
      r_epoch <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < 6; i++) begin
        r_snap[i]  <= w_cnt[i];
        r_delta[i] <= w_delta[i];
      end
      r_epoch <= r_epoch + 32'd1;
    end
  end

  // One-cycle pulse marking the edge a new snapshot lands.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_commit;
    end
  end

  // Sticky overrun: any committed delta with bit 31 set; only clear resets it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_overrun <= 1'b0;
    end else if (ctrl_clear) begin
      r_overrun <= 1'b0;
    end else if (w_commit && w_big) begin
      r_overrun <= 1'b1;
    end
  end

`ifdef PR_STATS_RATE_PEAK_EN
  // Running maximum of each counter's committed delta.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 6; i++) r_peak[i] <= '0;
    end else if (ctrl_clear) begin
      for (int i = 0; i < 6; i++) r_peak[i] <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < 6; i++) begin
        if (w_delta[i] > r_peak[i]) r_peak[i] <= w_delta[i];
      end
    end
  end
`endif

  // Register-read decode from current (pre-update) register values.
  always_comb begin
    w_rd_data = '0;
    if (rd_req_addr <= 5'd5) begin
      w_rd_data = r_snap[w_idx];
    end else if (rd_req_addr >= 5'd8 && rd_req_addr <= 5'd13) begin
      w_rd_data = r_delta[w_idx];
    end else if (rd_req_addr == 5'd14) begin
      w_rd_data = r_epoch;
    end else if (rd_req_addr == 5'd15) begin
      w_rd_data = {29'b0, r_overrun, ctrl_freeze, 1'b1};
`ifdef PR_STATS_RATE_PEAK_EN
    end else if (rd_req_addr >= 5'd16 && rd_req_addr <= 5'd21) begin
      w_rd_data = r_peak[w_idx];
`endif
    end
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Read FSM next state: stay in RSP while stalled or while reads stream.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RD_IDLE: if (w_accept) w_state_next = RD_RSP;
      RD_RSP: begin
        if (w_accept)          w_state_next = RD_RSP;
        else if (rd_rsp_ready) w_state_next = RD_IDLE;
      end
      default: w_state_next = RD_IDLE;
    endcase
  end

  // Response data loads only on accept, so it holds during a stall.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rsp_data <= '0;
    end else if (w_accept) begin
      r_rsp_data <= w_rd_data;
    end
  end

endmodule

// File: tb/tb_pr_stats_rate.sv
// tb_pr_stats_rate: directed stimulus for pr_stats_rate with a behavioural
// model compared every cycle, plus hand-computed literal register reads.
// Honours PR_STATS_RATE_PEAK_EN for the peak-register expectations.
module tb_pr_stats_rate;

  localparam int INTERVAL = 16;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [191:0] xdma_stats;
  logic         ctrl_clear;
  logic         ctrl_freeze;
  logic         rd_req_valid;
  logic         rd_req_ready;
  logic [4:0]   rd_req_addr;
  logic         rd_rsp_valid;
  logic         rd_rsp_ready;
  logic [31:0]  rd_rsp_data;
  logic         tick;

  logic [31:0]  cnt [6];

  int errors = 0;
  int checks = 0;
  bit checkEn = 0;

  // Model state
  logic [31:0] mPrev [6];
  logic [31:0] mSnap [6];
  logic [31:0] mDelta [6];
  logic [31:0] mPeak [6];
  logic [31:0] mEpoch;
  logic        mOverrun;
  logic        mTick;
  int          mPhase;
  logic [31:0] rspQ [$];
  logic [31:0] mD;
  logic [31:0] mRd;
  bit          mAcc;
  bit          mCon;

  pr_stats_rate #(.INTERVAL_CYCLES(INTERVAL), .TMR_BITS(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .xdma_stats(xdma_stats),
    .ctrl_clear(ctrl_clear), .ctrl_freeze(ctrl_freeze),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data), .tick(tick)
  );

  assign xdma_stats = {cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], cnt[5]};

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] val);
    cnt[idx] = val;
  endtask

  // What a read of address a returns given the model's current registers.
  function automatic logic [31:0] readModel(input logic [4:0] a);
    int ai = int'(a);
    if (ai <= 5) return mSnap[ai];
    if (ai >= 8 && ai <= 13) return mDelta[ai-8];
    if (ai == 14) return mEpoch;
    if (ai == 15) return {29'b0, mOverrun, ctrl_freeze, 1'b1};
`ifdef PR_STATS_RATE_PEAK_EN
    if (ai >= 16 && ai <= 21) return mPeak[ai-16];
`endif
    return 32'd0;
  endfunction

  // Behavioural model: one-deep response queue plus interval sampling rules.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 6; i++) begin
        mPrev[i] = 0; mSnap[i] = 0; mDelta[i] = 0; mPeak[i] = 0;
      end
      mEpoch = 0; mOverrun = 0; mTick = 0; mPhase = 0;
      rspQ.delete();
    end else begin
      mCon = (rspQ.size() > 0) && rd_rsp_ready;
      mAcc = rd_req_valid && ((rspQ.size() == 0) || rd_rsp_ready);
      mRd  = readModel(rd_req_addr);
      if (mCon) void'(rspQ.pop_front());
      if (mAcc) rspQ.push_back(mRd);
      mTick = 0;
      if (ctrl_clear) begin
        for (int i = 0; i < 6; i++) begin
          mPrev[i] = cnt[i];
          mPeak[i] = 0;
        end
        mOverrun = 0;
        mPhase = 0;
      end else begin
        if (mPhase == INTERVAL - 1 && !ctrl_freeze) begin
          for (int i = 0; i < 6; i++) begin
            mD = cnt[i] - mPrev[i];
            mDelta[i] = mD;
            mSnap[i] = cnt[i];
            mPrev[i] = cnt[i];
            if (mD > 32'h7FFFFFFF) mOverrun = 1;
            if (mD > mPeak[i]) mPeak[i] = mD;
          end
          mEpoch = mEpoch + 1;
          mTick = 1;
        end
        mPhase = (mPhase + 1) % INTERVAL;
      end
    end
  end

  // Per-cycle compare of all outputs against the model, 1 ns after the edge.
  always @(posedge aclk) begin
    #1;
    if (checkEn && aresetn) begin
      checkOutput("cyc_tick", {31'b0, tick}, {31'b0, mTick});
      checkOutput("cyc_rsp_valid", {31'b0, rd_rsp_valid}, {31'b0, rspQ.size() > 0});
      checkOutput("cyc_req_ready", {31'b0, rd_req_ready},
                  {31'b0, (rspQ.size() == 0) || rd_rsp_ready});
      if (rspQ.size() > 0) checkOutput("cyc_rsp_data", rd_rsp_data, rspQ[0]);
    end
  end

  task automatic waitTick(input string nm);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 64) begin
      @(posedge aclk); #1;
      n++;
      if (tick) seen = 1;
    end
    checkOutput({nm, "_tick_seen"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic doRead(input logic [4:0] a, input logic [31:0] exp, input string nm);
    @(negedge aclk);
    rd_req_valid = 1; rd_req_addr = a; rd_rsp_ready = 1;
    @(posedge aclk); #1;
    checkOutput({nm, "_valid"}, {31'b0, rd_rsp_valid}, 32'd1);
    checkOutput(nm, rd_rsp_data, exp);
    @(negedge aclk);
    rd_req_valid = 0;
  endtask

  task automatic pulseClear();
    @(negedge aclk); ctrl_clear = 1;
    @(negedge aclk); ctrl_clear = 0;
  endtask

  initial begin
    aresetn = 1; ctrl_clear = 0; ctrl_freeze = 0;
    rd_req_valid = 0; rd_req_addr = 0; rd_rsp_ready = 1;
    for (int i = 0; i < 6; i++) applyStimulus(i, 32'd0);
    applyStimulus(0, 32'd100);
    applyStimulus(1, 32'd7);
    #2 aresetn = 0;
    #20;
    checkOutput("rst_req_ready", {31'b0, rd_req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rd_rsp_valid}, 32'd0);
    checkOutput("rst_tick", {31'b0, tick}, 32'd0);
    checkOutput("rst_rsp_data", rd_rsp_data, 32'd0);
    @(negedge aclk); aresetn = 1; checkEn = 1;

    // First interval: delta equals cumulative value
    waitTick("first");
    doRead(5'd0, 32'd100, "snap0_first");
    doRead(5'd8, 32'd100, "delta0_first");
    doRead(5'd14, 32'd1, "epoch_first");
    doRead(5'd15, 32'd1, "status_first");
    doRead(5'd7, 32'd0, "addr7_zero");
    doRead(5'd9, 32'd7, "delta1_first");

    // Counter wrap after re-baselining at 0xFFFFFFF0
    @(negedge aclk); applyStimulus(0, 32'hFFFFFFF0); ctrl_clear = 1;
    @(negedge aclk); ctrl_clear = 0;
    waitTick("wrapN");
    @(negedge aclk); applyStimulus(0, 32'h00000010);
    waitTick("wrapN1");
    doRead(5'd8, 32'h20, "delta0_wrap");
    doRead(5'd15, 32'd1, "status_wrap");
    doRead(5'd14, 32'd3, "epoch_wrap");

    // Clear on the exact sample cycle suppresses the snapshot
    waitTick("pre_clear");
    repeat (INTERVAL - 1) @(posedge aclk);
    @(negedge aclk); ctrl_clear = 1; applyStimulus(0, 32'h50);
    @(negedge aclk); ctrl_clear = 0; applyStimulus(0, 32'h58);
    doRead(5'd14, 32'd4, "epoch_after_clear");
    waitTick("post_clear");
    doRead(5'd8, 32'd8, "delta0_post_clear");
    doRead(5'd14, 32'd5, "epoch_post_clear");

    // Freeze across two or more sample cycles
    @(negedge aclk); ctrl_freeze = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge aclk); applyStimulus(2, cnt[2] + 32'd3);
    end
    doRead(5'd14, 32'd5, "epoch_frozen");
    doRead(5'd8, 32'd8, "delta0_frozen");
    doRead(5'd15, 32'd3, "status_frozen");
    doRead(5'd0, 32'h58, "snap0_frozen");
    @(negedge aclk); applyStimulus(0, 32'h70); ctrl_freeze = 0;
    waitTick("unfreeze");
    doRead(5'd10, 32'd120, "delta2_unfreeze");

    // Back-to-back reads with a 3-cycle response stall
    @(negedge aclk); rd_rsp_ready = 0; rd_req_valid = 1; rd_req_addr = 5'd8;
    @(posedge aclk); #1;
    checkOutput("bp_first_data", rd_rsp_data, 32'h18);
    @(negedge aclk); rd_req_addr = 5'd14;
    for (int k = 0; k < 3; k++) begin
      @(posedge aclk); #1;
      checkOutput("bp_stall_ready", {31'b0, rd_req_ready}, 32'd0);
      checkOutput("bp_stall_data", rd_rsp_data, 32'h18);
    end
    @(negedge aclk); rd_rsp_ready = 1;
    @(posedge aclk); #1;
    checkOutput("bp_second_data", rd_rsp_data, 32'd6);
    @(negedge aclk); rd_req_addr = 5'd7;
    @(posedge aclk); #1;
    checkOutput("bp_addr7_data", rd_rsp_data, 32'd0);
    @(negedge aclk); rd_req_valid = 0;

    // Overrun boundary: 0x7FFFFFFF does not set it, 0x80000000 does
    waitTick("ovr_base");
    @(negedge aclk); applyStimulus(1, cnt[1] + 32'h7FFFFFFF);
    waitTick("ovr_edge");
    doRead(5'd15, 32'd1, "status_no_ovr");
    doRead(5'd9, 32'h7FFFFFFF, "delta1_edge");
    @(negedge aclk); applyStimulus(1, cnt[1] + 32'h80000000);
    waitTick("ovr_set");
    doRead(5'd15, 32'd5, "status_ovr");
    doRead(5'd9, 32'h80000000, "delta1_ovr");

    // Peak tracking on c3 with deltas 5, 40, 12
    @(negedge aclk); applyStimulus(3, cnt[3] + 32'd5);
    waitTick("peak_a");
    @(negedge aclk); applyStimulus(3, cnt[3] + 32'd40);
    waitTick("peak_b");
    @(negedge aclk); applyStimulus(3, cnt[3] + 32'd12);
    waitTick("peak_c");
    doRead(5'd11, 32'd12, "delta3_last");
`ifdef PR_STATS_RATE_PEAK_EN
    doRead(5'd19, 32'd40, "peak3");
`else
    doRead(5'd19, 32'd0, "peak3");
`endif
    pulseClear();
    doRead(5'd19, 32'd0, "peak3_cleared");
    doRead(5'd15, 32'd1, "status_cleared");
    doRead(5'd14, 32'd12, "epoch_cleared");

    // Reset with a response pending drops it
    @(negedge aclk); rd_rsp_ready = 0; rd_req_valid = 1; rd_req_addr = 5'd14;
    @(posedge aclk); #1;
    checkOutput("pend_valid", {31'b0, rd_rsp_valid}, 32'd1);
    @(negedge aclk); rd_req_valid = 0; aresetn = 0;
    #1;
    checkOutput("midrst_rsp_valid", {31'b0, rd_rsp_valid}, 32'd0);
    checkOutput("midrst_req_ready", {31'b0, rd_req_ready}, 32'd1);
    checkOutput("midrst_rsp_data", rd_rsp_data, 32'd0);
    @(negedge aclk); aresetn = 1; rd_rsp_ready = 1;
    doRead(5'd14, 32'd0, "epoch_after_rst");
    doRead(5'd8, 32'd0, "delta0_after_rst");

    repeat (4) @(posedge aclk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
